// File: rtl/read_batch_buffer.sv
// Ping-pong read store: one bank accepts cache-line beats while the other
// presents reads to the pipeline and answers symbol lookups.
module read_batch_buffer #(
  parameter int CL             = 512,
  parameter int READ_NUM_WIDTH = 6,
  parameter int SEQ_LINES      = 2,
  parameter int QPOS_WIDTH     = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [CL-1:0]             load_data,
  input  logic [READ_NUM_WIDTH:0]   batch_size,
  output logic                      load_done,
  input  logic                      batch_release,
  input  logic                      stall,
  input  logic                      new_read,
  output logic                      new_read_valid,
  output logic [READ_NUM_WIDTH-1:0] new_read_num,
  output logic [63:0]               new_ik_x0,
  output logic [63:0]               new_ik_x1,
  output logic [63:0]               new_ik_x2,
  output logic [63:0]               new_ik_info,
  output logic [6:0]                new_forward_i,
  output logic [6:0]                new_min_intv,
  input  logic [5:0]                status_query,
  input  logic [QPOS_WIDTH-1:0]     query_position,
  input  logic [READ_NUM_WIDTH-1:0] query_read_num,
  output logic [7:0]                new_read_query,
  output logic                      new_read_query_valid,
  output logic [63:0]               primary,
  output logic [63:0]               L2_0,
  output logic [63:0]               L2_1,
  output logic [63:0]               L2_2,
  output logic [63:0]               L2_3
);

  localparam int MAX_READ   = 1 << READ_NUM_WIDTH;
  localparam int SW         = READ_NUM_WIDTH + 1;
  localparam int BEATS      = SEQ_LINES + 2;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LINE_W     = (SEQ_LINES > 1) ? $clog2(SEQ_LINES) : 1;
  localparam int SYM_LINE   = CL / 8;
  localparam int HALF_SYM   = CL / 16;
  localparam int SYM_W      = $clog2(SYM_LINE);
  localparam int OFF_W      = $clog2(HALF_SYM);
  localparam int HALF_WORDS = (HALF_SYM + 7) / 8;
  localparam int HALF_PAD   = HALF_WORDS * 64;
  localparam int WORD_W     = (HALF_WORDS > 1) ? $clog2(HALF_WORDS) : 1;
  localparam int SADDR_W    = 1 + READ_NUM_WIDTH + LINE_W;
  localparam int IADDR_W    = 1 + READ_NUM_WIDTH;

  typedef enum logic {L_IDLE, L_LOAD} lstate_t;

  lstate_t                   lstate_q, lstate_d;
  logic                      load_bank_q, load_bank_d;
  logic                      serve_bank_q, serve_bank_d;
  logic [1:0]                bank_full_q, bank_full_d;
  logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [READ_NUM_WIDTH-1:0] read_cnt_q, read_cnt_d;
  logic [1:0][SW-1:0]        size_q, size_d;
  logic [SW-1:0]             read_ptr_q, read_ptr_d;

  logic          load_fire;
  logic          last_beat;
  logic [SW-1:0] batch_clamped;
  logic [SW-1:0] cur_size;
  logic          is_sym, is_param, is_ik;
  logic          rel_ok;

  // ---------------- load FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lstate_q <= L_IDLE;
    else       lstate_q <= lstate_d;
  end

  always_comb begin
    lstate_d = lstate_q;
    case (lstate_q)
      L_IDLE:  if (load_fire && !last_beat) lstate_d = L_LOAD;
      L_LOAD:  if (last_beat) lstate_d = L_IDLE;
      default: lstate_d = L_IDLE;
    endcase
  end

  always_comb begin
    load_ready = !bank_full_q[load_bank_q] && ((batch_size != '0) || (lstate_q == L_LOAD));
  end

  assign batch_clamped = (batch_size > SW'(MAX_READ)) ? SW'(MAX_READ) : batch_size;
  // The first beat of a batch must judge "last read" against the size it is about to latch.
  assign cur_size  = (lstate_q == L_IDLE) ? batch_clamped : size_q[load_bank_q];
  assign load_fire = load_valid && load_ready;
  assign last_beat = load_fire && (beat_cnt_q == BEAT_W'(BEATS - 1)) &&
                     ({1'b0, read_cnt_q} == cur_size - SW'(1));
  assign is_sym    = beat_cnt_q < BEAT_W'(SEQ_LINES);
  assign is_param  = beat_cnt_q == BEAT_W'(SEQ_LINES);
  assign is_ik     = beat_cnt_q == BEAT_W'(SEQ_LINES + 1);

  assign load_done      = bank_full_q[serve_bank_q];
  assign new_read_valid = load_done && (read_ptr_q < size_q[serve_bank_q]);
  assign rel_ok         = batch_release && load_done && (read_ptr_q == size_q[serve_bank_q]);

  always_comb begin
    load_bank_d  = load_bank_q;
    serve_bank_d = serve_bank_q;
    bank_full_d  = bank_full_q;
    beat_cnt_d   = beat_cnt_q;
    read_cnt_d   = read_cnt_q;
    size_d       = size_q;
    read_ptr_d   = read_ptr_q;

    if (!stall && new_read && new_read_valid) read_ptr_d = read_ptr_q + SW'(1);

    if (rel_ok) begin
      bank_full_d[serve_bank_q] = 1'b0;
      serve_bank_d              = !serve_bank_q;
      read_ptr_d                = '0;
    end

    // Applied after the release so a same-cycle completion on that bank leaves it full.
    if (load_fire) begin
      if (lstate_q == L_IDLE) size_d[load_bank_q] = batch_clamped;
      if (last_beat) begin
        bank_full_d[load_bank_q] = 1'b1;
        load_bank_d              = !load_bank_q;
        beat_cnt_d               = '0;
        read_cnt_d               = '0;
      end else if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
        beat_cnt_d = '0;
        read_cnt_d = read_cnt_q + READ_NUM_WIDTH'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_bank_q  <= 1'b0;
      serve_bank_q <= 1'b0;
      bank_full_q  <= '0;
      beat_cnt_q   <= '0;
      read_cnt_q   <= '0;
      size_q       <= '0;
      read_ptr_q   <= '0;
    end else begin
      load_bank_q  <= load_bank_d;
      serve_bank_q <= serve_bank_d;
      bank_full_q  <= bank_full_d;
      beat_cnt_q   <= beat_cnt_d;
      read_cnt_q   <= read_cnt_d;
      size_q       <= size_d;
      read_ptr_q   <= read_ptr_d;
    end
  end

  // ---------------- storage ----------------
  logic [CL/2-1:0] sym_lo_mem [2**SADDR_W];
  logic [CL/2-1:0] sym_hi_mem [2**SADDR_W];
  logic [255:0]    ik_mem     [2**IADDR_W];
  logic [6:0]      fwd_mem    [2**IADDR_W];
  logic [6:0]      min_mem    [2**IADDR_W];
  logic [63:0]     prim_q     [2];
  logic [255:0]    l2_q       [2];

  logic [SADDR_W-1:0] sym_waddr;
  logic [IADDR_W-1:0] iss_waddr;
  logic [255:0]       l2_src;

  assign sym_waddr = {load_bank_q, read_cnt_q, LINE_W'(beat_cnt_q)};
  assign iss_waddr = {load_bank_q, read_cnt_q};
  assign l2_src    = 256'(load_data >> 256);

  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (is_sym) begin
        sym_lo_mem[sym_waddr] <= load_data[CL/2-1:0];
        sym_hi_mem[sym_waddr] <= load_data[CL-1:CL/2];
      end
      if (is_param) begin
        fwd_mem[iss_waddr] <= load_data[6:0];
        min_mem[iss_waddr] <= load_data[70:64];
        if (read_cnt_q == '0) prim_q[load_bank_q] <= load_data[191:128];
      end
      if (is_ik) begin
        ik_mem[iss_waddr] <= load_data[255:0];
        if (read_cnt_q == '0) l2_q[load_bank_q] <= l2_src;
      end
    end
  end

  // ---------------- issue outputs ----------------
  logic [IADDR_W-1:0] iss_raddr;
  logic [255:0]       ik_rd;

  assign iss_raddr = {serve_bank_q, read_ptr_q[READ_NUM_WIDTH-1:0]};
  assign ik_rd     = ik_mem[iss_raddr];

  always_comb begin
    new_read_num  = '1;
    new_ik_x0     = 64'h1111_1111_1111_1111;
    new_ik_x1     = 64'h1111_1111_1111_1111;
    new_ik_x2     = 64'h1111_1111_1111_1111;
    new_ik_info   = 64'h1111_1111_1111_1111;
    new_forward_i = 7'h7F;
    new_min_intv  = 7'h7F;
    if (new_read_valid) begin
      new_read_num  = read_ptr_q[READ_NUM_WIDTH-1:0];
      new_ik_x0     = ik_rd[63:0];
      new_ik_x1     = ik_rd[127:64];
      new_ik_x2     = ik_rd[191:128];
      new_ik_info   = ik_rd[255:192];
      new_forward_i = fwd_mem[iss_raddr];
      new_min_intv  = min_mem[iss_raddr];
    end
  end

  always_comb begin
    primary = '0;
    L2_0    = '0;
    L2_1    = '0;
    L2_2    = '0;
    L2_3    = '0;
    if (load_done) begin
      primary = prim_q[serve_bank_q];
      L2_0    = l2_q[serve_bank_q][63:0];
      L2_1    = l2_q[serve_bank_q][127:64];
      L2_2    = l2_q[serve_bank_q][191:128];
      L2_3    = l2_q[serve_bank_q][255:192];
    end
  end

  // ---------------- query pipe ----------------
  logic [SYM_W-1:0]   q_sym;
  logic [LINE_W-1:0]  q_line;
  logic               q_upper;
  logic [OFF_W-1:0]   q_off;
  logic               q_bubble;
  logic [SADDR_W-1:0] q_addr;

  always_comb begin
    q_line   = LINE_W'(int'(query_position) / SYM_LINE);
    q_sym    = SYM_W'(int'(query_position) % SYM_LINE);
    q_upper  = int'(q_sym) >= HALF_SYM;
    q_off    = q_upper ? OFF_W'(int'(q_sym) - HALF_SYM) : OFF_W'(q_sym);
    q_addr   = {serve_bank_q, query_read_num, q_line};
    q_bubble = (status_query == 6'h30) || (status_query == 6'h02) ||
               (status_query == 6'h06) ||
               ({1'b0, query_read_num} >= size_q[serve_bank_q]) ||
               !bank_full_q[serve_bank_q];
  end

  logic [CL/2-1:0]     s1_half_q;
  logic [OFF_W-1:0]    s1_off_q;
  logic                s1_live_q;
  logic [63:0]         s2_word_q;
  logic [2:0]          s2_bsel_q;
  logic                s2_live_q;
  logic [7:0]          query_q;
  logic                query_vld_q;
  logic [HALF_PAD-1:0] s1_half_pad;
  logic [63:0]         s1_words [HALF_WORDS];
  logic [WORD_W-1:0]   s1_word_idx;
  logic [7:0]          s2_byte;

  assign s1_half_pad = HALF_PAD'(s1_half_q);
  for (genvar gi = 0; gi < HALF_WORDS; gi++) begin : g_words
    assign s1_words[gi] = s1_half_pad[gi*64 +: 64];
  end
  assign s1_word_idx = WORD_W'(s1_off_q >> 3);
  assign s2_byte     = s2_word_q[{s2_bsel_q, 3'b000} +: 8];

  // Bank and read are resolved into the RAM address here, so a release in flight cannot disturb the lookup.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_half_q <= q_upper ? sym_hi_mem[q_addr] : sym_lo_mem[q_addr];
      s1_off_q  <= q_off;
      s2_word_q <= s1_words[s1_word_idx];
      s2_bsel_q <= s1_off_q[2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_live_q   <= 1'b0;
      s2_live_q   <= 1'b0;
      query_q     <= 8'hFF;
      query_vld_q <= 1'b0;
    end else if (!stall) begin
      s1_live_q   <= !q_bubble;
      s2_live_q   <= s1_live_q;
      query_q     <= s2_live_q ? s2_byte : 8'hFF;
      query_vld_q <= s2_live_q;
    end
  end

  assign new_read_query       = query_q;
  assign new_read_query_valid = query_vld_q;

endmodule
